pool1d_window_buffer: RTL and testbench

//  Upstream stage of the 1-D pooling datapath. Takes a serial element stream, one element per beat.

---
 rtl/pool1d_pkg.sv | 28 ++
 rtl/pool1d_pos_counter.sv | 78 +++++++
 rtl/pool1d_window_buffer.sv | 127 ++++++++++++
 tb/tb_pool1d_window_buffer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool1d_pkg.sv
// Shared helpers for the 1-D pooling window buffer: output-length and counter-width
// functions plus the default element type.
package pool1d_pkg;

  localparam int unsigned POOL1D_ELEM_W = 8;

  typedef logic [POOL1D_ELEM_W-1:0] pool1d_elem_t;

  // Guards keep elaboration alive on illegal configs so the top-level $error is what reports them.
  function automatic int unsigned pool1d_out_len(input int unsigned l, input int unsigned k,
                                                 input int unsigned s, input int unsigned p);
    if (s == 0 || (l + 2 * p) < k) return 1;
    return (l + 2 * p - k) / s + 1;
  endfunction

  function automatic int unsigned pool1d_cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned pool1d_pos_w(input int unsigned l, input int unsigned p);
    return pool1d_cnt_w(l + 2 * p);
  endfunction

  function automatic int unsigned pool1d_row_w(input int unsigned r);
    return pool1d_cnt_w(r);
  endfunction

endpackage

// File: rtl/pool1d_pos_counter.sv
// Position / row / stride bookkeeping for the window buffer: decides whether the next
// padded step is a pad, whether it completes a window, and whether that window ends a row.
module pool1d_pos_counter
  import pool1d_pkg::*;
#(
  parameter int unsigned L = 8,
  parameter int unsigned R = 1,
  parameter int unsigned K = 2,
  parameter int unsigned S = 2,
  parameter int unsigned P = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_step,
  output logic o_pad,
  output logic o_emit,
  output logic o_last
);

  localparam int unsigned LP      = L + 2 * P;
  localparam int unsigned OUT_LEN = pool1d_out_len(L, K, S, P);
  localparam int unsigned POS_W   = pool1d_pos_w(L, P);
  localparam int unsigned ROW_W   = pool1d_row_w(R);
  localparam int unsigned PH_W    = pool1d_cnt_w(S);
  localparam int unsigned WI_W    = pool1d_cnt_w(OUT_LEN + 1);

  logic [POS_W-1:0] r_pos;
  logic [ROW_W-1:0] r_row;
  logic [PH_W-1:0]  r_phase;
  logic [WI_W-1:0]  r_widx;

  logic w_lead;
  logic w_tail;
  logic w_full;
  logic w_wrap;

  // Degenerate bounds are resolved at elaboration so no comparison is constant.
  if (P == 0) begin : g_nopad
    assign w_lead = 1'b0;
    assign w_tail = 1'b0;
  end else begin : g_pad
    assign w_lead = (r_pos < POS_W'(P));
    assign w_tail = (r_pos >= POS_W'(P + L));
  end

  if (K == 1) begin : g_k1
    assign w_full = 1'b1;
  end else begin : g_kn
    assign w_full = (r_pos >= POS_W'(K - 1));
  end

  assign o_pad  = w_lead || w_tail;
  assign o_emit = w_full && (r_phase == '0) && (r_widx < WI_W'(OUT_LEN));
  assign o_last = o_emit && (r_widx == WI_W'(OUT_LEN - 1));
  assign w_wrap = (r_pos == POS_W'(LP - 1));

  // r_phase counts steps since the first complete window modulo S; r_widx counts emitted windows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos   <= '0;
      r_row   <= '0;
      r_phase <= '0;
      r_widx  <= '0;
    end else if (i_step) begin
      if (w_wrap) begin
        r_pos   <= '0;
        r_phase <= '0;
        r_widx  <= '0;
        r_row   <= (r_row == ROW_W'(R - 1)) ? '0 : r_row + 1'b1;
      end else begin
        r_pos <= r_pos + 1'b1;
        if (w_full) r_phase <= (r_phase == PH_W'(S - 1)) ? '0 : r_phase + 1'b1;
        if (o_emit) r_widx <= r_widx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pool1d_window_buffer.sv
// Serial-to-window front end of the 1-D pooling datapath: zero-pads each row and
// presents sliding K-element windows. Define POOL1D_WINDOW_LAST_EN to add data_out_0_last.
module pool1d_window_buffer
  import pool1d_pkg::*;
#(
  parameter int unsigned DATA_IN_0_PRECISION_0       = 8,
  parameter int unsigned DATA_IN_0_PRECISION_1       = 3,
  parameter int unsigned DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
  parameter int unsigned DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
  parameter int unsigned KERNEL_SIZE                 = 2,
  parameter int unsigned STRIDE                      = 2,
  parameter int unsigned PADDING                     = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0,
  input  logic                             data_in_0_valid,
  output logic                             data_in_0_ready,
  output logic [DATA_IN_0_PRECISION_0-1:0] data_out_0 [KERNEL_SIZE],
  output logic                             data_out_0_valid,
  input  logic                             data_out_0_ready
`ifdef POOL1D_WINDOW_LAST_EN
  ,
  output logic                             data_out_0_last
`endif
);

  localparam int unsigned W  = DATA_IN_0_PRECISION_0;
  localparam int unsigned L  = DATA_IN_0_TENSOR_SIZE_DIM_0;
  localparam int unsigned R  = DATA_IN_0_TENSOR_SIZE_DIM_1;
  localparam int unsigned K  = KERNEL_SIZE;
  localparam int unsigned S  = STRIDE;
  localparam int unsigned P  = PADDING;
  localparam int unsigned LP = L + 2 * P;

  typedef logic [W-1:0] elem_t;

  if (L < 1) begin : g_chk_l
    $error("pool1d_window_buffer: row length must be at least 1");
  end
  if (S < 1) begin : g_chk_s
    $error("pool1d_window_buffer: stride must be at least 1");
  end
  if (K < 1 || K > LP) begin : g_chk_k
    $error("pool1d_window_buffer: kernel must fit inside the padded row");
  end
  if (R < 1) begin : g_chk_r
    $error("pool1d_window_buffer: at least one row per tensor");
  end
  if (DATA_IN_0_PRECISION_1 > DATA_IN_0_PRECISION_0) begin : g_chk_frac
    $error("pool1d_window_buffer: fractional bits exceed element width");
  end

  logic  w_pad;
  logic  w_emit;
  logic  w_last;
  logic  w_step_ok;
  logic  w_step;
  elem_t w_elem;
  elem_t w_next_win [K];
  elem_t r_win      [K];
  elem_t r_dout     [K];
  logic  r_dout_valid;

  pool1d_pos_counter #(
    .L(L),
    .R(R),
    .K(K),
    .S(S),
    .P(P)
  ) u_pos (
    .clk   (clk),
    .rst   (rst),
    .i_step(w_step),
    .o_pad (w_pad),
    .o_emit(w_emit),
    .o_last(w_last)
  );

  // Only a window-completing step can be blocked, and only by an unconsumed window.
  assign w_step_ok       = !w_emit || !r_dout_valid || data_out_0_ready;
  assign data_in_0_ready = !rst && !w_pad && w_step_ok;
  assign w_step          = !rst && w_step_ok && (w_pad || data_in_0_valid);
  assign w_elem          = w_pad ? '0 : data_in_0;

  always_comb begin
    w_next_win = r_win;
    for (int unsigned i = 0; i + 1 < K; i++) w_next_win[i] = r_win[i+1];
    w_next_win[K-1] = w_elem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < K; i++) begin
        r_win[i]  <= '0;
        r_dout[i] <= '0;
      end
      r_dout_valid <= 1'b0;
    end else begin
      if (w_step) r_win <= w_next_win;
      if (w_step && w_emit) begin
        r_dout       <= w_next_win;
        r_dout_valid <= 1'b1;
      end else if (data_out_0_ready) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign data_out_0       = r_dout;
  assign data_out_0_valid = r_dout_valid;

`ifdef POOL1D_WINDOW_LAST_EN
  logic r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_last <= 1'b0;
    else if (w_step && w_emit) r_last <= w_last;
  end

  assign data_out_0_last = r_last;
`else
  logic w_unused_last;
  assign w_unused_last = w_last;
`endif

endmodule

// File: tb/tb_pool1d_window_buffer.sv
// Self-checking bench for pool1d_window_buffer: three configurations driven with directed
// and randomized streams, checked against an index-arithmetic model of the padded windows.
module tb_pool1d_window_buffer;

`ifdef POOL1D_WINDOW_LAST_EN
  localparam bit LAST_ON = 1'b1;
`else
  localparam bit LAST_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] din  [3];
  logic       vin  [3];
  logic       ordy [3];
  logic       rin_a, rin_b, rin_c;
  logic       ovld_a, ovld_b, ovld_c;
  logic [7:0] dout_a [2];
  logic [7:0] dout_b [3];
  logic [7:0] dout_c [2];
`ifdef POOL1D_WINDOW_LAST_EN
  logic       last_a, last_b, last_c;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  stim_q[$];
  logic [24:0] exp_q[$];
  logic        inrdy_trace[$];
  int          run_cycles;

  pool1d_window_buffer #(
    .DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(3),
    .DATA_IN_0_TENSOR_SIZE_DIM_0(8), .DATA_IN_0_TENSOR_SIZE_DIM_1(1),
    .KERNEL_SIZE(2), .STRIDE(2), .PADDING(0)
  ) u_a (
    .clk(clk), .rst(rst), .data_in_0(din[0]), .data_in_0_valid(vin[0]), .data_in_0_ready(rin_a),
    .data_out_0(dout_a), .data_out_0_valid(ovld_a), .data_out_0_ready(ordy[0])
`ifdef POOL1D_WINDOW_LAST_EN
    , .data_out_0_last(last_a)
`endif
  );

  pool1d_window_buffer #(
    .DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(3),
    .DATA_IN_0_TENSOR_SIZE_DIM_0(4), .DATA_IN_0_TENSOR_SIZE_DIM_1(1),
    .KERNEL_SIZE(3), .STRIDE(1), .PADDING(1)
  ) u_b (
    .clk(clk), .rst(rst), .data_in_0(din[1]), .data_in_0_valid(vin[1]), .data_in_0_ready(rin_b),
    .data_out_0(dout_b), .data_out_0_valid(ovld_b), .data_out_0_ready(ordy[1])
`ifdef POOL1D_WINDOW_LAST_EN
    , .data_out_0_last(last_b)
`endif
  );

  pool1d_window_buffer #(
    .DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(3),
    .DATA_IN_0_TENSOR_SIZE_DIM_0(5), .DATA_IN_0_TENSOR_SIZE_DIM_1(2),
    .KERNEL_SIZE(2), .STRIDE(2), .PADDING(0)
  ) u_c (
    .clk(clk), .rst(rst), .data_in_0(din[2]), .data_in_0_valid(vin[2]), .data_in_0_ready(rin_c),
    .data_out_0(dout_c), .data_out_0_valid(ovld_c), .data_out_0_ready(ordy[2])
`ifdef POOL1D_WINDOW_LAST_EN
    , .data_out_0_last(last_c)
`endif
  );

  function automatic int cfg_l(input int s); return (s == 0) ? 8 : (s == 1) ? 4 : 5; endfunction
  function automatic int cfg_k(input int s); return (s == 1) ? 3 : 2; endfunction
  function automatic int cfg_s(input int s); return (s == 1) ? 1 : 2; endfunction
  function automatic int cfg_p(input int s); return (s == 1) ? 1 : 0; endfunction

  function automatic logic get_rin(input int s);
    return (s == 0) ? rin_a : (s == 1) ? rin_b : rin_c;
  endfunction

  function automatic logic get_ovld(input int s);
    return (s == 0) ? ovld_a : (s == 1) ? ovld_b : ovld_c;
  endfunction

  function automatic logic [23:0] get_win(input int s);
    logic [23:0] w;
    case (s)
      0:       w = {8'h00, dout_a[1], dout_a[0]};
      1:       w = {dout_b[2], dout_b[1], dout_b[0]};
      default: w = {8'h00, dout_c[1], dout_c[0]};
    endcase
    return w;
  endfunction

  function automatic logic get_last(input int s);
`ifdef POOL1D_WINDOW_LAST_EN
    return (s == 0) ? last_a : (s == 1) ? last_b : last_c;
`else
    return (s < 0);
`endif
  endfunction

  // Window j of a row covers padded indices j*S .. j*S+K-1; padded index q maps to element q-P.
  task automatic build_expected(input int s);
    int l, k, st, p, nout, rows, q;
    logic [23:0] w;
    l = cfg_l(s); k = cfg_k(s); st = cfg_s(s); p = cfg_p(s);
    nout = (l + 2 * p - k) / st + 1;
    rows = stim_q.size() / l;
    exp_q.delete();
    for (int r = 0; r < rows; r++) begin
      for (int j = 0; j < nout; j++) begin
        w = '0;
        for (int t = 0; t < k; t++) begin
          q = j * st + t - p;
          if (q >= 0 && q < l) w[8*t +: 8] = stim_q[r*l + q];
        end
        exp_q.push_back({LAST_ON && (j == nout - 1), w});
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin vin[i] = 1'b0; ordy[i] = 1'b1; din[i] = '0; end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_seq(input int n, input bit rnd);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(rnd ? 8'($urandom) : 8'(i + 1));
  endtask

  task automatic run_stream(input int s, input int p_valid, input int p_ready,
                            input int stall_from, input int stall_len, input int budget);
    int idx, oidx, cyc;
    logic held, v;
    logic [24:0] held_w, got;
    idx = 0; oidx = 0; cyc = 0; held = 1'b0; held_w = '0;
    build_expected(s);
    inrdy_trace.delete();
    while ((idx < stim_q.size() || oidx < exp_q.size()) && cyc < budget) begin
      @(negedge clk);
      v = (idx < stim_q.size()) && ($urandom_range(99) < p_valid);
      vin[s] = v;
      din[s] = v ? stim_q[idx] : 8'($urandom);
      ordy[s] = ($urandom_range(99) < p_ready) && !(cyc >= stall_from && cyc < stall_from + stall_len);
      #1;
      inrdy_trace.push_back(get_rin(s));
      got = {get_last(s), get_win(s)};
      if (held) begin
        n_vec++;
        if (!get_ovld(s) || got !== held_w) begin
          n_err++;
          $display("FAIL hold[%0d] cyc %0d: got valid=%b win=%h want valid=1 win=%h", s, cyc, get_ovld(s), got, held_w);
        end
      end
      if (v && get_rin(s)) idx++;
      if (get_ovld(s) && ordy[s]) begin
        n_vec++;
        if (oidx >= exp_q.size()) begin
          n_err++;
          $display("FAIL extra[%0d] cyc %0d: got win=%h want none", s, cyc, got);
        end else if (got !== exp_q[oidx]) begin
          n_err++;
          $display("FAIL window[%0d] #%0d: got %h want %h", s, oidx, got, exp_q[oidx]);
        end
        oidx++;
      end
      held = get_ovld(s) && !ordy[s];
      held_w = got;
      cyc++;
    end
    run_cycles = cyc;
    n_vec++;
    if (oidx != exp_q.size() || idx != stim_q.size()) begin
      n_err++;
      $display("FAIL complete[%0d]: got %0d in %0d out want %0d in %0d out", s, idx, oidx, stim_q.size(), exp_q.size());
    end
    @(negedge clk);
    vin[s] = 1'b0; ordy[s] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_vec++;
      if (get_ovld(s) !== 1'b0) begin
        n_err++;
        $display("FAIL idle[%0d] cyc %0d: got valid=%b want 0", s, c, get_ovld(s));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin vin[i] = 1'b1; ordy[i] = 1'b1; din[i] = 8'hA5; end
    #1;
    for (int s = 0; s < 3; s++) begin
      n_vec++;
      if (get_rin(s) !== 1'b0 || get_ovld(s) !== 1'b0 || get_win(s) !== 24'h0 || get_last(s) !== 1'b0) begin
        n_err++;
        $display("FAIL reset[%0d]: got rdy=%b vld=%b win=%h last=%b want 0 0 0 0", s, get_rin(s), get_ovld(s), get_win(s), get_last(s));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      n_vec++;
      if (get_rin(s) !== (cfg_p(s) == 0)) begin
        n_err++;
        $display("FAIL ready_after_reset[%0d]: got %b want %b", s, get_rin(s), cfg_p(s) == 0);
      end
    end
  endtask

  task automatic test_case1_latency();
    logic exp_v;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vin[0] = (c < 8); din[0] = 8'(c + 1); ordy[0] = 1'b1;
      #1;
      exp_v = (c >= 2) && (c % 2 == 0);
      n_vec++;
      if (ovld_a !== exp_v || (exp_v && get_win(0) !== {8'h00, 8'(c), 8'(c - 1)}) || (c < 8 && rin_a !== 1'b1)) begin
        n_err++;
        $display("FAIL latency cyc %0d: got vld=%b win=%h rdy=%b want vld=%b win=%h rdy=1",
                 c, ovld_a, get_win(0), rin_a, exp_v, {8'h00, 8'(c), 8'(c - 1)});
      end
    end
    vin[0] = 1'b0;
  endtask

  task automatic test_case2_padding();
    do_reset();
    load_seq(4, 1'b0);
    run_stream(1, 100, 100, 0, 0, 100);
  endtask

  task automatic test_case3_rows();
    do_reset();
    load_seq(10, 1'b0);
    run_stream(2, 100, 100, 0, 0, 100);
  endtask

  task automatic test_backpressure();
    do_reset();
    load_seq(8, 1'b0);
    run_stream(0, 100, 100, 2, 5, 200);
    n_vec++;
    if (inrdy_trace.size() < 8 || inrdy_trace[2] !== 1'b1 || inrdy_trace[3] !== 1'b0 ||
        inrdy_trace[6] !== 1'b0 || inrdy_trace[7] !== 1'b1) begin
      n_err++;
      $display("FAIL stall_ready: got trace len %0d c2..c7 %b%b%b%b%b%b want 100001", inrdy_trace.size(),
               inrdy_trace[2], inrdy_trace[3], inrdy_trace[4], inrdy_trace[5], inrdy_trace[6], inrdy_trace[7]);
    end
  endtask

  task automatic test_reset_midstream();
    int idx, cyc;
    do_reset();
    idx = 0; cyc = 0;
    while (idx < 2 && cyc < 20) begin
      @(negedge clk);
      vin[1] = 1'b1; din[1] = 8'(idx + 1); ordy[1] = 1'b0;
      #1;
      if (rin_b) idx++;
      cyc++;
    end
    @(negedge clk);
    vin[1] = 1'b0;
    #1;
    n_vec++;
    if (ovld_b !== 1'b1 || get_win(1) !== 24'h020100) begin
      n_err++;
      $display("FAIL pre_reset_window: got vld=%b win=%h want 1 020100", ovld_b, get_win(1));
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (ovld_b !== 1'b0 || get_win(1) !== 24'h0 || rin_b !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got vld=%b win=%h rdy=%b want 0 0 0", ovld_b, get_win(1), rin_b);
    end
    @(negedge clk);
    rst = 1'b0;
    ordy[1] = 1'b1;
    load_seq(4, 1'b0);
    run_stream(1, 100, 100, 0, 0, 100);
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_seq(8, 1'b1);
    run_stream(1, 100, 100, 0, 0, 100);
    n_vec++;
    if (run_cycles !== 12) begin
      n_err++;
      $display("FAIL throughput: got %0d cycles want 12", run_cycles);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 3; s++) begin
      for (int pass = 0; pass < 2; pass++) begin
        do_reset();
        load_seq(cfg_l(s) * 4, 1'b1);
        run_stream(s, (pass == 0) ? 70 : 90, (pass == 0) ? 60 : 30, 0, 0, 2000);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin vin[i] = 1'b0; ordy[i] = 1'b1; din[i] = '0; end
    test_reset();
    test_case1_latency();
    test_case2_padding();
    test_case3_rows();
    test_backpressure();
    test_reset_midstream();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
